// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg
//   Shared constants and helpers for the skid-buffered pipeline stage.
//   Per-stage payload structs live in the CPU type package; this package
//   only carries what the stage register itself needs.
package pipe_stage_skid_pkg;

    // Width of the occupancy count (0..2 entries).
    localparam int OCC_W = 2;

    // Number of valid entries held, from the two slot valid bits.
    function automatic logic [OCC_W-1:0] count_valid(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
//   One valid/ready handshake channel carrying an opaque payload and a
//   halt marker.
//   master: drives valid, data, halt; samples ready.
//   slave : samples valid, data, halt; drives ready.
interface pipe_stage_skid_if
    import pipe_stage_skid_pkg::*;
#(
    parameter int PAYLOAD_W = 128
);
    logic                 valid;
    logic                 ready;
    logic                 halt;
    logic [PAYLOAD_W-1:0] data;

    modport master (output valid, output data, output halt, input ready);
    modport slave  (input valid, input data, input halt, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// pipe_stage_skid_slot
//   One storage slot of the stage: valid bit, halt bit and payload.
//   Ports:
//     clk, srst      clock and synchronous active-high reset
//     flush          squash: clears valid/halt, zeroes payload if BUBBLE_ZERO
//     load           capture d_halt/d_data and mark valid
//     drop           clear valid/halt only (payload kept, entry simply left)
//     d_halt, d_data entry being loaded
//     valid, halt, data  slot contents
//   Priority: srst > flush > load > drop.
module pipe_stage_skid_slot
    import pipe_stage_skid_pkg::*;
#(
    parameter int PAYLOAD_W   = 128,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 drop,
    input  logic                 d_halt,
    input  logic [PAYLOAD_W-1:0] d_data,
    output logic                 valid,
    output logic                 halt,
    output logic [PAYLOAD_W-1:0] data
);

    logic                 valid_reg;
    logic                 halt_reg;
    logic [PAYLOAD_W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            valid_reg <= 1'b0;
            halt_reg  <= 1'b0;
            // With BUBBLE_ZERO=0 the payload is left as-is; only the
            // valid bit marks the slot as a bubble.
            if (BUBBLE_ZERO) begin
                data_reg <= '0;
            end
        end else if (load) begin
            valid_reg <= 1'b1;
            halt_reg  <= d_halt;
            data_reg  <= d_data;
        end else if (drop) begin
            // A normal departure: the payload stays visible but invalid.
            valid_reg <= 1'b0;
            halt_reg  <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign halt  = halt_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Back-pressurable pipeline stage register with a 2-entry skid buffer,
//   flush (bubble insertion) and sticky halt tracking. The main slot drives
//   the downstream channel; the skid slot catches one entry accepted while
//   the main slot is stalled, so in_ready never depends combinationally on
//   out_ready.
//   Ports:
//     CLK, RST   clock (rising edge), synchronous active-high reset
//     up         upstream channel (slave): valid/data/halt in, ready out
//     dn         downstream channel (master): valid/data/halt out, ready in
//     flush      squash all held entries and any same-cycle input
//     halted     sticky: a halt entry has left the stage
//     occupancy  number of valid entries held (0..2)
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int PAYLOAD_W   = 128,
    parameter bit BUBBLE_ZERO = 1'b1,
    parameter bit HALT_BLOCKS = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    input  logic                flush,
    output logic                halted,
    output logic [OCC_W-1:0]    occupancy
);

    logic                 main_valid, main_halt;
    logic [PAYLOAD_W-1:0] main_data;
    logic                 skid_valid, skid_halt;
    logic [PAYLOAD_W-1:0] skid_data;

    logic halt_seen_reg, halt_seen_next;
    logic halted_reg, halted_next;

    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic                 main_take;
    logic                 main_load, main_drop;
    logic                 skid_load, skid_drop;
    logic                 main_d_halt;
    logic [PAYLOAD_W-1:0] main_d_data;

    // Pure register decode: a full skid slot or a blocking halt refuses input.
    assign in_ready = !skid_valid && !(HALT_BLOCKS && halt_seen_reg);
    assign in_fire  = up.valid && in_ready;
    assign out_fire = main_valid && dn.ready;

    // The main slot can take a new entry when it is empty or draining.
    assign main_take = !main_valid || out_fire;

    always_comb begin
        main_load   = 1'b0;
        main_drop   = 1'b0;
        skid_load   = 1'b0;
        skid_drop   = 1'b0;
        main_d_halt = up.halt;
        main_d_data = up.data;
        if (!flush) begin
            if (main_take) begin
                if (skid_valid) begin
                    // Skid entry is older than anything upstream; it goes first.
                    main_load   = 1'b1;
                    main_d_halt = skid_halt;
                    main_d_data = skid_data;
                    skid_drop   = 1'b1;
                end else if (in_fire) begin
                    main_load = 1'b1;
                end else begin
                    main_drop = 1'b1;
                end
            end else if (in_fire) begin
                // Main is stalled with a valid entry: park the input.
                skid_load = 1'b1;
            end
        end
    end

    // A halt that leaves is recorded even in a flush cycle: downstream took it.
    assign halted_next = halted_reg || (out_fire && main_halt);

    always_comb begin
        halt_seen_next = halt_seen_reg;
        if (flush) begin
            // Every held halt is squashed (and any incoming one discarded);
            // only a halt that has already left keeps the stage blocked.
            halt_seen_next = halted_next;
        end else if (in_fire && up.halt) begin
            halt_seen_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_seen_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            halt_seen_reg <= halt_seen_next;
            halted_reg    <= halted_next;
        end
    end

    pipe_stage_skid_slot #(
        .PAYLOAD_W   (PAYLOAD_W),
        .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_main (
        .clk    (CLK),
        .srst   (RST),
        .flush  (flush),
        .load   (main_load),
        .drop   (main_drop),
        .d_halt (main_d_halt),
        .d_data (main_d_data),
        .valid  (main_valid),
        .halt   (main_halt),
        .data   (main_data)
    );

    pipe_stage_skid_slot #(
        .PAYLOAD_W   (PAYLOAD_W),
        .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_skid (
        .clk    (CLK),
        .srst   (RST),
        .flush  (flush),
        .load   (skid_load),
        .drop   (skid_drop),
        .d_halt (up.halt),
        .d_data (up.data),
        .valid  (skid_valid),
        .halt   (skid_halt),
        .data   (skid_data)
    );

    assign up.ready  = in_ready;
    assign dn.valid  = main_valid;
    assign dn.halt   = main_valid && main_halt;
    assign dn.data   = main_data;
    assign halted    = halted_reg;
    assign occupancy = count_valid(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Directed scenarios with literal expectations, then randomized traffic
//   checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         halted;
    logic [1:0]   occupancy;

    pipe_stage_skid_if #(.PAYLOAD_W(W)) up_if ();
    pipe_stage_skid_if #(.PAYLOAD_W(W)) dn_if ();

    pipe_stage_skid #(
        .PAYLOAD_W   (W),
        .BUBBLE_ZERO (1'b1),
        .HALT_BLOCKS (1'b1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .flush     (flush),
        .halted    (halted),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: FIFO of held entries ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         h;
    } ent_t;

    ent_t         q[$];
    bit           m_halt_seen = 1'b0;
    bit           m_halted    = 1'b0;
    logic [W-1:0] m_shadow    = '0;   // what out_data shows (last main payload)
    bit           armed       = 1'b0;

    always @(posedge clk) begin
        bit   m_in_ready, in_f, out_f;
        ent_t e;
        m_in_ready = (q.size() < 2) && !m_halt_seen;
        in_f  = up_if.valid && m_in_ready;
        out_f = (q.size() > 0) && dn_if.ready;
        if (rst) begin
            q.delete();
            m_halt_seen = 1'b0;
            m_halted    = 1'b0;
            m_shadow    = '0;
            armed       = 1'b1;
        end else if (flush) begin
            if (out_f && q[0].h) m_halted = 1'b1;
            q.delete();
            m_halt_seen = m_halted;
            m_shadow    = '0;
        end else begin
            if (out_f) begin
                if (q[0].h) m_halted = 1'b1;
                void'(q.pop_front());
            end
            if (in_f) begin
                e.d = up_if.data;
                e.h = up_if.halt;
                q.push_back(e);
                if (e.h) m_halt_seen = 1'b1;
            end
            if (q.size() > 0) m_shadow = q[0].d;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", W'(dn_if.valid), W'(q.size() > 0));
            chk("out_halt",  W'(dn_if.halt),  W'((q.size() > 0) && q[0].h));
            chk("out_data",  dn_if.data,      m_shadow);
            chk("occupancy", W'(occupancy),   W'(q.size()));
            chk("in_ready",  W'(up_if.ready), W'((q.size() < 2) && !m_halt_seen));
            chk("halted",    W'(halted),      W'(m_halted));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic h,
                         input logic ordy, input logic fl);
        up_if.valid = v;
        up_if.data  = d;
        up_if.halt  = h;
        dn_if.ready = ordy;
        flush       = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();

        // Reset then idle.
        do_reset();
        step();
        chk("rst_out_valid", W'(dn_if.valid), 0);
        chk("rst_occ",       W'(occupancy),   0);
        chk("rst_in_ready",  W'(up_if.ready), 1);
        chk("rst_out_data",  dn_if.data,      0);
        chk("rst_halted",    W'(halted),      0);
        $display("txn reset/idle done");

        // Stream 1,2,3 at full rate.
        drive(1'b1, 32'h1, 1'b0, 1'b1, 1'b0); step();
        chk("stream_d1", dn_if.data, 32'h1); chk("stream_occ1", W'(occupancy), 1);
        drive(1'b1, 32'h2, 1'b0, 1'b1, 1'b0); step();
        chk("stream_d2", dn_if.data, 32'h2); chk("stream_occ2", W'(occupancy), 1);
        drive(1'b1, 32'h3, 1'b0, 1'b1, 1'b0); step();
        chk("stream_d3", dn_if.data, 32'h3); chk("stream_occ3", W'(occupancy), 1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
        chk("stream_drained", W'(dn_if.valid), 0);
        $display("txn stream 1,2,3 done");

        // Skid fill and drain.
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); step();
        chk("skid_occ2",     W'(occupancy),   2);
        chk("skid_in_ready", W'(up_if.ready), 0);
        chk("skid_head_A",   dn_if.data,      32'hA);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
        chk("skid_head_B",   dn_if.data,      32'hB);
        chk("skid_ready_back", W'(up_if.ready), 1);
        step();
        chk("skid_empty",    W'(occupancy),   0);
        $display("txn skid fill/drain done");

        // Flush a full stage while 0xC is offered.
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1); step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", W'(dn_if.valid), 0);
        chk("flush_occ",   W'(occupancy),   0);
        chk("flush_data",  dn_if.data,      0);
        step();
        chk("flush_no_C",  W'(dn_if.valid), 0);
        $display("txn flush full stage done");

        // Halt entry exits, stage blocks until reset.
        drive(1'b1, 32'hD, 1'b1, 1'b0, 1'b0); step();
        chk("halt_in_ready", W'(up_if.ready), 0);
        chk("halt_out_halt", W'(dn_if.halt),  1);
        drive(1'b1, 32'hE, 1'b0, 1'b1, 1'b0); step();
        chk("halt_gone",     W'(dn_if.halt),  0);
        chk("halt_halted",   W'(halted),      1);
        step(); step();
        chk("halt_sticky",   W'(halted),      1);
        chk("halt_ignored",  W'(dn_if.valid), 0);
        do_reset();
        chk("halt_rst",      W'(halted),      0);
        $display("txn halt exit/sticky done");

        // Halt flushed before leaving.
        drive(1'b1, 32'hF, 1'b1, 1'b0, 1'b0); step();
        chk("hflush_blocked", W'(up_if.ready), 0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("hflush_ready",  W'(up_if.ready), 1);
        chk("hflush_halted", W'(halted),      0);
        $display("txn halt flush done");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 15) == 0));
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        $display("txn random traffic done (3000 cycles)");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
